// File: rtl/alarm_pio_pkg.sv
// Shared definitions for the alarm PIO: register map, CTRL/STATUS bit positions,
// FSM encoding and the STATUS word packer.
package alarm_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_SET     = 3'd1;
  localparam logic [2:0] ADDR_CLEAR   = 3'd2;
  localparam logic [2:0] ADDR_CTRL    = 3'd3;
  localparam logic [2:0] ADDR_PERIOD  = 3'd4;
  localparam logic [2:0] ADDR_TIMEOUT = 3'd5;
  localparam logic [2:0] ADDR_STATUS  = 3'd6;

  localparam int CTRL_BLINK_BIT   = 0;
  localparam int CTRL_IRQ_BIT     = 1;
  localparam int STAT_RINGING_BIT = 0;
  localparam int STAT_EXPIRED_BIT = 1;
  localparam int STAT_PHASE_BIT   = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RINGING = 1'b1
  } alarm_state_e;

  function automatic logic [2:0] pack_status(input logic ringing,
                                             input logic expired,
                                             input logic phase);
    logic [2:0] s;
    s = 3'b000;
    s[STAT_RINGING_BIT] = ringing;
    s[STAT_EXPIRED_BIT] = expired;
    s[STAT_PHASE_BIT]   = phase;
    return s;
  endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// Tick prescaler: counts 0..TICK_DIV-1 and flags the last count for one clk;
// a synchronous clear holds it at zero.
module alarm_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Prescaler counter, wrapping at LAST, cleared whenever the alarm is not ringing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/alarm_pio_ctrl.sv
// Avalon-MM alarm output port: DATA mask with atomic set/clear, ticked blink
// and auto-off timeout raising a level interrupt.
module alarm_pio_ctrl
  import alarm_pio_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int TICK_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  alarm_state_e     state_r, state_nx_s;
  logic [WIDTH-1:0] data_r, data_nx_s;
  logic [1:0]       ctrl_r, ctrl_nx_s;
  logic [CNT_W-1:0] period_r, period_nx_s;
  logic [CNT_W-1:0] timeout_r, timeout_nx_s;
  logic [CNT_W-1:0] half_cnt_r, half_cnt_nx_s;
  logic [CNT_W-1:0] to_cnt_r, to_cnt_nx_s;
  logic             phase_r, phase_nx_s;
  logic             expired_r, expired_nx_s;
  logic [WIDTH-1:0] out_port_r, out_nx_s;
  logic             irq_r, irq_nx_s;

  logic             wr_s;
  logic             expire_s;
  logic             tick_s;
  logic             tick_clr_s;
  logic [WIDTH-1:0] wd_s;
  logic [31:0]      rd_s;
  logic             unused_s;

  assign wd_s     = writedata[WIDTH-1:0];
  assign unused_s = ^writedata;

  alarm_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tick_clr_s),
    .tick    (tick_s)
  );

  // Bus-side register updates; a bus write to DATA wins over a same-cycle expiry.
  always_comb begin
    wr_s     = chipselect & ~write_n;
    expire_s = (state_r == ST_RINGING) && tick_s && (to_cnt_r == CNT_W'(1));

    if (wr_s && (address == ADDR_DATA)) begin
      data_nx_s = wd_s;
    end else if (wr_s && (address == ADDR_SET)) begin
      data_nx_s = data_r | wd_s;
    end else if (wr_s && (address == ADDR_CLEAR)) begin
      data_nx_s = data_r & ~wd_s;
    end else if (expire_s) begin
      data_nx_s = '0;
    end else begin
      data_nx_s = data_r;
    end

    if (wr_s && (address == ADDR_CTRL)) begin
      ctrl_nx_s = writedata[1:0];
    end else begin
      ctrl_nx_s = ctrl_r;
    end

    if (wr_s && (address == ADDR_PERIOD)) begin
      period_nx_s = writedata[CNT_W-1:0];
    end else begin
      period_nx_s = period_r;
    end

    if (wr_s && (address == ADDR_TIMEOUT)) begin
      timeout_nx_s = writedata[CNT_W-1:0];
    end else begin
      timeout_nx_s = timeout_r;
    end

    if (expire_s) begin
      expired_nx_s = 1'b1;
    end else if (wr_s && (address == ADDR_STATUS) && writedata[STAT_EXPIRED_BIT]) begin
      expired_nx_s = 1'b0;
    end else begin
      expired_nx_s = expired_r;
    end
  end

  // FSM next state plus blink phase and half-period / timeout counters.
  always_comb begin
    state_nx_s    = state_r;
    phase_nx_s    = phase_r;
    half_cnt_nx_s = half_cnt_r;
    to_cnt_nx_s   = to_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (data_nx_s != '0) begin
          state_nx_s    = ST_RINGING;
          phase_nx_s    = 1'b1;
          half_cnt_nx_s = period_r;
          to_cnt_nx_s   = timeout_r;
        end else begin
          state_nx_s = ST_IDLE;
          phase_nx_s = 1'b0;
        end
      end
      ST_RINGING: begin
        if (data_nx_s == '0) begin
          state_nx_s = ST_IDLE;
          phase_nx_s = 1'b0;
        end else if (tick_s) begin
          if (half_cnt_r == '0) begin
            phase_nx_s    = ~phase_r;
            half_cnt_nx_s = period_r;
          end else begin
            half_cnt_nx_s = half_cnt_r - CNT_W'(1);
          end
          // A zero count latched at entry means the timeout is disabled.
          if (to_cnt_r != '0) begin
            to_cnt_nx_s = to_cnt_r - CNT_W'(1);
          end else begin
            to_cnt_nx_s = to_cnt_r;
          end
        end else begin
          state_nx_s = ST_RINGING;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        phase_nx_s = 1'b0;
      end
    endcase

    tick_clr_s = !((state_r == ST_RINGING) && (state_nx_s == ST_RINGING));

    if (ctrl_nx_s[CTRL_BLINK_BIT]) begin
      out_nx_s = data_nx_s & {WIDTH{phase_nx_s}};
    end else begin
      out_nx_s = data_nx_s;
    end
    irq_nx_s = expired_nx_s & ctrl_nx_s[CTRL_IRQ_BIT];
  end

  // All state and the registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      data_r     <= '0;
      ctrl_r     <= 2'b00;
      period_r   <= '0;
      timeout_r  <= '0;
      half_cnt_r <= '0;
      to_cnt_r   <= '0;
      phase_r    <= 1'b0;
      expired_r  <= 1'b0;
      out_port_r <= '0;
      irq_r      <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      data_r     <= data_nx_s;
      ctrl_r     <= ctrl_nx_s;
      period_r   <= period_nx_s;
      timeout_r  <= timeout_nx_s;
      half_cnt_r <= half_cnt_nx_s;
      to_cnt_r   <= to_cnt_nx_s;
      phase_r    <= phase_nx_s;
      expired_r  <= expired_nx_s;
      out_port_r <= out_nx_s;
      irq_r      <= irq_nx_s;
    end
  end

  // Zero-latency read mux; unused bits and write-only addresses read zero.
  always_comb begin
    rd_s = 32'h0000_0000;
    case (address)
      ADDR_DATA:    rd_s[WIDTH-1:0] = data_r;
      ADDR_CTRL:    rd_s[1:0]       = ctrl_r;
      ADDR_PERIOD:  rd_s[CNT_W-1:0] = period_r;
      ADDR_TIMEOUT: rd_s[CNT_W-1:0] = timeout_r;
      ADDR_STATUS:  rd_s[2:0]       = pack_status(state_r == ST_RINGING, expired_r, phase_r);
      default:      rd_s            = 32'h0000_0000;
    endcase
  end

  assign readdata = rd_s;
  assign out_port = out_port_r;
  assign irq      = irq_r;

endmodule
